// File: rtl/approx_mul_pkg.sv
// Shared constants and reference helpers for the tiled approximate multiplier.
package approx_mul_pkg;

  localparam int         TILE_W     = 4;
  localparam logic [7:0] TRUNC_MASK = 8'hFC;

  // Bit position at which tile (i,j) lands in the full product.
  function automatic int tile_weight(input int i, input int j);
    return TILE_W * (i + j);
  endfunction

  // Bit-accurate behavioural model of the tiled product. Operands are
  // zero-extended to 16 bits. The result is truncated to 2*w bits.
  function automatic logic [31:0] approx_ref(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic        mode,
                                             input int          w,
                                             input int          approx_w);
    logic [31:0] acc;
    logic [7:0]  t;
    acc = '0;
    for (int i = 0; i < w / TILE_W; i++) begin
      for (int j = 0; j < w / TILE_W; j++) begin
        t = 8'(a[TILE_W*i +: TILE_W]) * 8'(b[TILE_W*j +: TILE_W]);
        if (mode && (tile_weight(i, j) < approx_w)) t = t & TRUNC_MASK;
        acc = acc + (32'(t) << tile_weight(i, j));
      end
    end
    if (w < 16) acc = acc & ((32'd1 << (2 * w)) - 32'd1);
    return acc;
  endfunction

endpackage

// File: rtl/tile_mul_4.sv
// Combinational 4x4 unsigned tile multiplier with optional two-LSB truncation.
module tile_mul_4
  import approx_mul_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       trunc,
  output logic [7:0] p
);

  logic [7:0] full;

  assign full = {4'b0000, a} * {4'b0000, b};
  assign p    = trunc ? (full & TRUNC_MASK) : full;

endmodule

// File: rtl/approx_mul_pipe.sv
// Three-stage pipelined unsigned multiplier assembled from 4x4 tiles.
// Approximate mode truncates the low-weight tiles; a single global
// advance signal stalls every stage together under backpressure.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int W        = 8,
  parameter int APPROX_W = 8,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_prod,
  output logic             out_mode,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N  = W / TILE_W;
  localparam int NT = N * N;
  localparam int PW = 2 * W;

  if ((W % TILE_W) != 0 || W > 16 || W < TILE_W) begin : g_bad_w
    $error("approx_mul_pipe: W must be 4, 8, 12 or 16");
  end

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic             v_s1;
  logic [W-1:0]     a_s1;
  logic [W-1:0]     b_s1;
  logic             mode_s1;
  logic [TAG_W-1:0] tag_s1;

  // S1: capture the accepted operand pair and its sideband.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_s1    <= 1'b0;
      a_s1    <= '0;
      b_s1    <= '0;
      mode_s1 <= 1'b0;
      tag_s1  <= '0;
    end else if (adv) begin
      v_s1 <= in_valid;
      if (in_valid) begin
        a_s1    <= in_a;
        b_s1    <= in_b;
        mode_s1 <= in_mode;
        tag_s1  <= in_tag;
      end
    end
  end

  logic [NT-1:0][7:0] tile_c;

  // Tile (i,j) multiplies nibble i of a by nibble j of b. Truncation is
  // enabled per tile at elaboration and gated by the transaction mode.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      localparam bit TRUNC_EN = (tile_weight(i, j) < APPROX_W);
      tile_mul_4 u_tile (
        .a     (a_s1[TILE_W*i +: TILE_W]),
        .b     (b_s1[TILE_W*j +: TILE_W]),
        .trunc (mode_s1 && TRUNC_EN),
        .p     (tile_c[i*N+j])
      );
    end
  end

  logic               v_s2;
  logic [NT-1:0][7:0] tile_s2;
  logic               mode_s2;
  logic [TAG_W-1:0]   tag_s2;

  // S2: register all partial-product tiles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_s2    <= 1'b0;
      tile_s2 <= '0;
      mode_s2 <= 1'b0;
      tag_s2  <= '0;
    end else if (adv) begin
      v_s2 <= v_s1;
      if (v_s1) begin
        tile_s2 <= tile_c;
        mode_s2 <= mode_s1;
        tag_s2  <= tag_s1;
      end
    end
  end

  logic [PW-1:0] sum_c;

  // Shift each tile to its weight and accumulate into the 2W-bit product.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sum_c = sum_c + (PW'(tile_s2[i*N+j]) << tile_weight(i, j));
      end
    end
  end

  // S3: output register; data only reloads on a real result so it stays
  // quiet across bubbles and frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_mode  <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= v_s2;
      if (v_s2) begin
        out_prod <= sum_c;
        out_mode <= mode_s2;
        out_tag  <= tag_s2;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Scoreboard bench for approx_mul_pipe at default parameters.
module tb_approx_mul_pipe;
  import approx_mul_pkg::*;

  localparam int W        = 8;
  localparam int APPROX_W = 8;
  localparam int TAG_W    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic             in_mode = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [2*W-1:0]   out_prod;
  logic             out_mode;
  logic [TAG_W-1:0] out_tag;

  approx_mul_pipe #(.W(W), .APPROX_W(APPROX_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_mode  (out_mode),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [2*W-1:0]   prod;
    logic             mode;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t exp_next;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: retire a result on an output transfer, record an expectation
  // on an input transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("prod", 64'(out_prod), 64'(e.prod));
          check("mode", 64'(out_mode), 64'(e.mode));
          check("tag", 64'(out_tag), 64'(e.tag));
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_next);
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                      input logic [TAG_W-1:0] t, input logic [2*W-1:0] e);
    int guard;
    guard    = 0;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    in_tag   = t;
    exp_next = '{e, m, t};
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic m);
    if (!m) return (2*W)'(a) * (2*W)'(b);
    return (2*W)'(approx_ref(16'(a), 16'(b), m, W, APPROX_W));
  endfunction

  task automatic wait_drain(input string tag);
    int guard;
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 100) begin
      guard++;
      @(posedge clk);
      #1;
    end
    check(tag, 64'(sb.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic             stream_done;
  logic [2*W-1:0]   snap_prod;
  logic [TAG_W-1:0] snap_tag;
  logic [W-1:0]     ra, rb;
  logic             rm;
  int               lat, c0;

  initial begin
    stream_done = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_prod", 64'(out_prod), 0);
    check("rst_out_mode", 64'(out_mode), 0);
    check("rst_out_tag", 64'(out_tag), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed values and latency
    send(8'hFF, 8'hFF, 1'b0, 4'd1, 16'hFE01);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 3);
    wait_drain("drain_ff_exact");
    send(8'hFF, 8'hFF, 1'b1, 4'd2, 16'hFDE0);
    send(8'h03, 8'h03, 1'b0, 4'd3, 16'h0009);
    send(8'h03, 8'h03, 1'b1, 4'd4, 16'h0008);
    send(8'h10, 8'h10, 1'b1, 4'd5, 16'h0100);
    send(8'h00, 8'hFF, 1'b1, 4'd6, 16'h0000);
    wait_drain("drain_directed");

    // Back-to-back stream, alternating modes
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rm = k[0];
      send(ra, rb, rm, 4'(k), ref_prod(ra, rb, rm));
    end
    check("stream_cycles", 64'(cyc - c0), 8);
    wait_drain("drain_stream");

    // Backpressure with a full pipe
    out_ready = 1'b0;
    send(8'hA5, 8'h5A, 1'b0, 4'd8, ref_prod(8'hA5, 8'h5A, 1'b0));
    send(8'h37, 8'hC3, 1'b1, 4'd9, ref_prod(8'h37, 8'hC3, 1'b1));
    send(8'hFF, 8'h01, 1'b1, 4'd10, ref_prod(8'hFF, 8'h01, 1'b1));
    in_a = 8'h12; in_b = 8'h34; in_mode = 1'b0; in_tag = 4'd11;
    exp_next = '{ref_prod(8'h12, 8'h34, 1'b0), 1'b0, 4'd11};
    in_valid = 1'b1;
    check("bp_head_tag", 64'(out_tag), 8);
    check("bp_head_prod", 64'(out_prod), 64'(ref_prod(8'hA5, 8'h5A, 1'b0)));
    snap_prod = out_prod;
    snap_tag  = out_tag;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #2;
      check("bp_in_ready", 64'(in_ready), 0);
      check("bp_out_valid", 64'(out_valid), 1);
      check("bp_prod_stable", 64'(out_prod), 64'(snap_prod));
      check("bp_tag_stable", 64'(out_tag), 64'(snap_tag));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain("drain_bp");

    // Asynchronous reset with three transactions in flight
    send(8'h11, 8'h22, 1'b0, 4'd1, ref_prod(8'h11, 8'h22, 1'b0));
    send(8'h33, 8'h44, 1'b1, 4'd2, ref_prod(8'h33, 8'h44, 1'b1));
    send(8'h55, 8'h66, 1'b0, 4'd3, ref_prod(8'h55, 8'h66, 1'b0));
    check("pre_rst_valid", 64'(out_valid), 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 0);
    check("async_rst_prod", 64'(out_prod), 0);
    sb.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #2;
      check("post_rst_quiet", 64'(out_valid), 0);
    end

    // Random stream under random backpressure
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(0, 255));
          rm = 1'($urandom_range(0, 1));
          send(ra, rb, rm, 4'(k), ref_prod(ra, rb, rm));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
